// File: rtl/mmio_link_port.sv
// MMIO-to-link bridge port.
// A host reaches a TX FIFO and an RX FIFO through a small MMIO word map.
// The TX FIFO drives a valid/ready link toward a PE. The RX FIFO accepts a valid/ready link
// coming from a PE.
// Optional build macro: MMIO_LINK_PORT_COUNTERS_EN adds transfer counters at indices 6 and 7.
module mmio_link_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 3,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mmio_read_req,
  input  logic [7:0]            mmio_read_index,
  output logic                  mmio_read_ack,
  output logic [DATA_WIDTH-1:0] mmio_read_data,
  input  logic                  mmio_write_req,
  input  logic [7:0]            mmio_write_index,
  input  logic [DATA_WIDTH-1:0] mmio_write_data,
  output logic                  mmio_write_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  in_valid,
  output logic                  in_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = TAG_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StAck, StWait} state_e;

  state_e                r_state, w_state_next;
  logic                  r_is_write;
  logic [7:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [TAG_WIDTH-1:0]  r_tx_tag;
  logic                  r_tx_ovf, r_rx_udf;

  logic [EW-1:0] r_tx_mem [DEPTH];
  logic [EW-1:0] r_rx_mem [DEPTH];
  logic [PW-1:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;

  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_commit, w_wr_commit, w_rd_commit;
  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic          w_tx_flush, w_rx_flush, w_clr_sticky;
  logic [EW-1:0] w_tx_head, w_rx_head;
  logic [31:0]   w_status;

  assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  assign w_rx_head  = r_rx_mem[r_rx_rptr];

  assign out_data  = w_tx_head[DATA_WIDTH-1:0];
  assign out_tag   = w_tx_head[EW-1:DATA_WIDTH];
  assign out_valid = !w_tx_empty;
  // Held low while in reset so the PE cannot hand off a word that reset would discard.
  assign in_ready  = reset_n && !w_rx_full;

  // Side effects commit at the end of the ACK cycle.
  assign w_commit     = (r_state == StAck);
  assign w_wr_commit  = w_commit && r_is_write;
  assign w_rd_commit  = w_commit && !r_is_write;
  assign w_tx_push    = w_wr_commit && (r_idx == 8'd0) && !w_tx_full;
  assign w_tx_pop     = out_valid && out_ready;
  assign w_rx_push    = in_valid && in_ready;
  assign w_rx_pop     = w_rd_commit && (r_idx == 8'd2) && !w_rx_empty;
  assign w_tx_flush   = w_wr_commit && (r_idx == 8'd5) && r_wdata[0];
  assign w_rx_flush   = w_wr_commit && (r_idx == 8'd5) && r_wdata[1];
  assign w_clr_sticky = w_wr_commit && (r_idx == 8'd5) && r_wdata[2];

  always_comb begin
    w_status        = '0;
    w_status[0]     = w_tx_full;
    w_status[1]     = w_rx_empty;
    w_status[2]     = r_tx_ovf;
    w_status[3]     = r_rx_udf;
    w_status[15:8]  = 8'(r_tx_cnt);
    w_status[23:16] = 8'(r_rx_cnt);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM next state and ack pulses; the write request wins over a simultaneous read.
  always_comb begin
    w_state_next   = r_state;
    mmio_read_ack  = 1'b0;
    mmio_write_ack = 1'b0;
    unique case (r_state)
      StIdle: if (mmio_write_req || mmio_read_req) w_state_next = StAck;
      StAck: begin
        w_state_next   = StWait;
        mmio_write_ack = r_is_write && reset_n;
        mmio_read_ack  = !r_is_write && reset_n;
      end
      StWait: if (r_is_write ? !mmio_write_req : !mmio_read_req) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Latch the accepted request while idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else if (r_state == StIdle) begin
      if (mmio_write_req) begin
        r_is_write <= 1'b1;
        r_idx      <= mmio_write_index;
        r_wdata    <= mmio_write_data;
      end else if (mmio_read_req) begin
        r_is_write <= 1'b0;
        r_idx      <= mmio_read_index;
      end
    end
  end

  // TX_TAG register and sticky error bits.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_tag <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      if (w_wr_commit && (r_idx == 8'd1)) r_tx_tag <= r_wdata[TAG_WIDTH-1:0];
      if (w_clr_sticky) begin
        r_tx_ovf <= 1'b0;
        r_rx_udf <= 1'b0;
      end else begin
        if (w_wr_commit && (r_idx == 8'd0) && w_tx_full)  r_tx_ovf <= 1'b1;
        if (w_rd_commit && (r_idx == 8'd2) && w_rx_empty) r_rx_udf <= 1'b1;
      end
    end
  end

  // TX FIFO; a flush beats any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (!reset_n || w_tx_flush) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= {r_tx_tag, r_wdata};
        r_tx_wptr           <= r_tx_wptr + PW'(1);
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + PW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  // RX FIFO; a flush beats any same-cycle push or pop.
  always_ff @(posedge clock) begin
    if (!reset_n || w_rx_flush) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= {in_tag, in_data};
        r_rx_wptr           <= r_rx_wptr + PW'(1);
      end
      if (w_rx_pop) r_rx_rptr <= r_rx_rptr + PW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

`ifdef MMIO_LINK_PORT_COUNTERS_EN
  logic [31:0] r_tx_sent, r_rx_received;

  // Wrapping link transfer counters.
  always_ff @(posedge clock) begin
    if (!reset_n || w_clr_sticky) begin
      r_tx_sent     <= '0;
      r_rx_received <= '0;
    end else begin
      if (w_tx_pop)  r_tx_sent     <= r_tx_sent + 32'd1;
      if (w_rx_push) r_rx_received <= r_rx_received + 32'd1;
    end
  end
`endif

  // Read data mux, driven only during a read ack.
  always_comb begin
    mmio_read_data = '0;
    if (mmio_read_ack) begin
      case (r_idx)
        8'd1: mmio_read_data = DATA_WIDTH'(r_tx_tag);
        8'd2: if (!w_rx_empty) mmio_read_data = w_rx_head[DATA_WIDTH-1:0];
        8'd3: if (!w_rx_empty) mmio_read_data = DATA_WIDTH'(w_rx_head[EW-1:DATA_WIDTH]);
        8'd4: mmio_read_data = DATA_WIDTH'(w_status);
`ifdef MMIO_LINK_PORT_COUNTERS_EN
        8'd6: mmio_read_data = DATA_WIDTH'(r_tx_sent);
        8'd7: mmio_read_data = DATA_WIDTH'(r_rx_received);
`endif
        default: mmio_read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_link_port.sv
// Directed bench for mmio_link_port (DEPTH=4). Expected read data and TX link words are queued
// when stimulus is issued and checked by monitors when the DUT produces them.
module tb_mmio_link_port;

  logic        clock, reset_n;
  logic        mmio_read_req, mmio_read_ack, mmio_write_req, mmio_write_ack;
  logic [7:0]  mmio_read_index, mmio_write_index;
  logic [31:0] mmio_read_data, mmio_write_data;
  logic [31:0] out_data, in_data;
  logic [2:0]  out_tag, in_tag;
  logic        out_valid, out_ready, in_valid, in_ready;

  typedef struct {
    string       tag;
    logic [34:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t tx_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  mmio_link_port dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .mmio_read_req   (mmio_read_req),
    .mmio_read_index (mmio_read_index),
    .mmio_read_ack   (mmio_read_ack),
    .mmio_read_data  (mmio_read_data),
    .mmio_write_req  (mmio_write_req),
    .mmio_write_index(mmio_write_index),
    .mmio_write_data (mmio_write_data),
    .mmio_write_ack  (mmio_write_ack),
    .out_data        (out_data),
    .out_tag         (out_tag),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .in_data         (in_data),
    .in_tag          (in_tag),
    .in_valid        (in_valid),
    .in_ready        (in_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read data monitor.
  always @(negedge clock) begin
    if (mmio_read_ack) begin
      if (rd_q.size() == 0) check_eq("rd_unexpected", 1, 0);
      else begin
        exp_t e;
        e = rd_q.pop_front();
        check_eq(e.tag, {32'd0, mmio_read_data}, {29'd0, e.val});
      end
    end
  end

  // TX link monitor: a transfer happens on the coming edge.
  always @(negedge clock) begin
    if (out_valid && out_ready && reset_n) begin
      if (tx_q.size() == 0) check_eq("tx_unexpected", 1, 0);
      else begin
        exp_t e;
        e = tx_q.pop_front();
        check_eq(e.tag, {29'd0, out_tag, out_data}, {29'd0, e.val});
      end
    end
  end

  task automatic mmio_write(input logic [7:0] idx, input logic [31:0] d);
    int n = 0;
    @(posedge clock); #1;
    mmio_write_req = 1'b1; mmio_write_index = idx; mmio_write_data = d;
    do begin @(negedge clock); n++; end while (!mmio_write_ack && n < 16);
    check_eq("wr_latency", n, 2);
    @(posedge clock); #1;
    mmio_write_req = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] idx, input logic [31:0] exp, input string tag);
    int n = 0;
    rd_q.push_back('{tag, {3'd0, exp}});
    @(posedge clock); #1;
    mmio_read_req = 1'b1; mmio_read_index = idx;
    do begin @(negedge clock); n++; end while (!mmio_read_ack && n < 16);
    check_eq("rd_latency", n, 2);
    @(posedge clock); #1;
    mmio_read_req = 1'b0;
  endtask

  task automatic rx_send(input logic [2:0] t, input logic [31:0] d);
    int n = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; in_tag = t; in_data = d;
    do begin @(negedge clock); n++; end while (!in_ready && n < 16);
    check_eq("rx_accept", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    int n = 0;
    while (out_valid && n < 32) begin @(negedge clock); n++; end
    check_eq("tx_drain", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; mmio_read_req = 1'b0; mmio_write_req = 1'b0;
    mmio_read_index = '0; mmio_write_index = '0; mmio_write_data = '0;
    out_ready = 1'b1; in_valid = 1'b0; in_tag = '0; in_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_wr_ack", mmio_write_ack, 0);
    check_eq("rst_rd_data", mmio_read_data, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("rel_in_ready", in_ready, 1);

    // Tagged TX word goes straight out.
    mmio_write(8'd1, 32'd5);
    mmio_read(8'd1, 32'd5, "tx_tag_rb");
    tx_q.push_back('{"tx_word", {3'd5, 32'hDEADBEEF}});
    mmio_write(8'd0, 32'hDEADBEEF);
    wait_tx_drain();
    mmio_read(8'd4, 32'h0000_0002, "status_tx_sent");

    // Overflow with the link stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_q.push_back('{"tx_ovf_word", {3'd5, 32'h100 + 32'(i)}});
      mmio_write(8'd0, 32'h100 + 32'(i));
    end
    mmio_read(8'd4, 32'h0000_0407, "status_ovf");
    mmio_write(8'd5, 32'd4);
    mmio_read(8'd4, 32'h0000_0403, "status_ovf_clr");
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_tx_drain();

    // RX ordering and underflow.
    rx_send(3'd1, 32'h10);
    rx_send(3'd2, 32'h20);
    rx_send(3'd3, 32'h30);
    mmio_read(8'd4, 32'h0003_0000, "status_rx3");
    mmio_read(8'd3, 32'd1, "rx_tag");
    mmio_read(8'd2, 32'h10, "rx_d0");
    mmio_read(8'd2, 32'h20, "rx_d1");
    mmio_read(8'd2, 32'h30, "rx_d2");
    mmio_read(8'd2, 32'h0, "rx_underflow_data");
    mmio_read(8'd4, 32'h0000_000A, "status_udf");
    mmio_write(8'd5, 32'd4);
    mmio_read(8'd200, 32'h0, "unmapped_rd");
    mmio_write(8'd9, 32'hFFFF_FFFF);

    // RX backpressure without loss.
    for (int i = 0; i < 4; i++) rx_send(3'(i), 32'hA0 + 32'(i));
    @(posedge clock); #1;
    in_valid = 1'b1; in_tag = 3'd4; in_data = 32'hA4;
    repeat (3) @(negedge clock);
    check_eq("rx_full_ready", in_ready, 0);
    mmio_read(8'd2, 32'hA0, "rx_bp_d0");
    @(negedge clock);
    check_eq("rx_ready_after_pop", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    mmio_read(8'd4, 32'h0004_0000, "status_rx_full");
    for (int i = 1; i < 5; i++) mmio_read(8'd2, 32'hA0 + 32'(i), "rx_bp_data");

    // Reset during the ACK cycle of a TX_DATA write.
    out_ready = 1'b0;
    @(posedge clock); #1;
    mmio_write_req = 1'b1; mmio_write_index = 8'd0; mmio_write_data = 32'h1234;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_ack", mmio_write_ack, 0);
    @(posedge clock); #1;
    reset_n = 1'b1; mmio_write_req = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_out_valid", out_valid, 0);
    mmio_read(8'd4, 32'h0000_0002, "rst_mid_status");
    mmio_read(8'd1, 32'h0, "rst_mid_tag");

    // Transfer counters.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back('{"tx_cnt_word", {3'd0, 32'h200 + 32'(i)}});
      mmio_write(8'd0, 32'h200 + 32'(i));
    end
    wait_tx_drain();
    rx_send(3'd6, 32'h55);
    rx_send(3'd7, 32'h66);
`ifdef MMIO_LINK_PORT_COUNTERS_EN
    mmio_read(8'd6, 32'd3, "cnt_tx_sent");
    mmio_read(8'd7, 32'd2, "cnt_rx_received");
`else
    mmio_read(8'd6, 32'd0, "cnt_tx_sent_off");
    mmio_read(8'd7, 32'd0, "cnt_rx_received_off");
`endif

    repeat (3) @(negedge clock);
    check_eq("rd_q_left", rd_q.size(), 0);
    check_eq("tx_q_left", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_link_port.md
MMIO_LINK_PORT -- requirements
Module: mmio_link_port

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, link data and MMIO data width.
- TAG_WIDTH, 3, link tag width.
- DEPTH, 4, entries per FIFO; power of two, 2..16.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock; all state updates on rising edge.
- reset_n, in, 1, reset; synchronous, active-low.
- mmio_read_req, in, 1, host read request; held until ack.
- mmio_read_index, in, 8, word index of the read.
- mmio_read_ack, out, 1, one-cycle read completion pulse.
- mmio_read_data, out, DATA_WIDTH, read data; valid only while mmio_read_ack=1.
- mmio_write_req, in, 1, host write request; held until ack.
- mmio_write_index, in, 8, word index of the write.
- mmio_write_data, in, DATA_WIDTH, write data.
- mmio_write_ack, out, 1, one-cycle write completion pulse.
- out_data / out_tag / out_valid, out, DATA_WIDTH / TAG_WIDTH / 1, TX link driving a PE input link.
- out_ready, in, 1, TX link backpressure.
- in_data / in_tag / in_valid, in, DATA_WIDTH / TAG_WIDTH / 1, RX link from a PE output link.
- in_ready, out, 1, RX link backpressure.

Function
REQ-003 The block SHALL contain a TX FIFO and an RX FIFO, each DEPTH entries of {tag, data}, with full, empty and count derived from wrapping pointers and an explicit count.
REQ-004 A link transfer SHALL occur on any cycle where valid=1 and ready=1.
REQ-005 The TX link SHALL present the TX FIFO head directly: out_valid = !tx_empty.
REQ-006 On the RX link, in_ready SHALL equal !rx_full.
REQ-007 A link pop and an MMIO push on the same FIFO in the same cycle SHALL both take effect, with the count unchanged.
REQ-008 The MMIO FSM SHALL have three states:
- IDLE: a write request has priority over a read request; IDLE->ACK.
- ACK: ack pulses for exactly one cycle and the side effect commits; ACK->WAIT.
- WAIT: return to IDLE when the acknowledged req is deasserted.
REQ-009 Each MMIO access SHALL therefore have a latency of exactly 1 cycle from req sampled to the ack pulse.
REQ-010 The word map SHALL be as follows:
- 0 TX_DATA (W): push {TX_TAG, data}.
- 1 TX_TAG (RW): low TAG_WIDTH bits; upper bits read as 0.
- 2 RX_DATA (R): return head data and pop.
- 3 RX_TAG (R): return head tag, zero-extended, no pop.
- 4 STATUS (R): bit0 tx_full, bit1 rx_empty, bit2 tx_overflow, bit3 rx_underflow, [15:8] tx_count, [23:16] rx_count.
- 5 CLEAR (W): bit0 flush TX, bit1 flush RX, bit2 clear both sticky bits.
REQ-011 A TX_DATA write while tx_full (full evaluated at the start of the cycle) SHALL drop the data and set tx_overflow; the ack still pulses.
REQ-012 An RX_DATA read while rx_empty SHALL return 0 and set rx_underflow.
REQ-013 Reads of unmapped indices SHALL return 0, writes to unmapped indices SHALL be ignored, and both SHALL still be acked.
REQ-014 A flush SHALL empty the FIFO in the commit cycle and take priority over a same-cycle link push or pop on that FIFO.

Reset
REQ-015 While reset_n=0 at a clock edge, the block SHALL drive the following:
- FIFOs empty, pointers 0.
- TX_TAG 0, sticky bits 0.
- FSM IDLE.
- mmio_read_ack=0, mmio_write_ack=0, mmio_read_data=0.
- out_valid=0, in_ready=0.
REQ-016 A reset asserted mid-access SHALL abort the access with no ack and no side effect; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-017 When the macro MMIO_LINK_PORT_COUNTERS_EN is defined, the block SHALL provide 32-bit wrapping counters tx_sent (index 6) and rx_received (index 7), incremented per link transfer and zeroed by reset or CLEAR bit2.
REQ-018 When MMIO_LINK_PORT_COUNTERS_EN is undefined, no counter logic SHALL exist and indices 6 and 7 SHALL read 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
- Write TX_TAG=5, then TX_DATA=0xDEADBEEF with out_ready=1 -> out_valid with tag 5 and data 0xDEADBEEF for one cycle; STATUS[15:8]=0 afterwards.
- out_ready=0, 5 TX_DATA writes with DEPTH=4 -> 4 entries queued, 5th dropped, STATUS bit2=1, bit0=1; CLEAR=4 clears bit2.
- Drive in tags 1,2,3 with data 0x10,0x20,0x30, then read RX_TAG, RX_DATA ×3 -> 1, 0x10, 0x20, 0x30 in order; a 4th RX_DATA read returns 0 and STATUS bit3=1.
- Fill RX (4 words), hold in_valid -> in_ready=0 and no loss; one RX_DATA read -> in_ready=1 next cycle and the 5th word accepted.
- Assert reset_n=0 during an ACK cycle of a TX_DATA write -> no ack, FIFO empty, out_valid=0.
- With MMIO_LINK_PORT_COUNTERS_EN: 3 TX and 2 RX transfers -> index 6 reads 3, index 7 reads 2; without the macro, both read 0.
